ext_world_io_ctrl: RTL and testbench
====================================

Name: ext_world_io_ctrl

Overview:
Memory-mapped controller that lets the RISCprocessor core share the four external-world input ports and four output ports through a single request/acknowledge bus.
- Input side: strobed input bytes are captured into per-port buffers, with pending and overrun flags.
- Output side: output ports are register-driven.
- A round-robin scheduler hands the core the next pending input port.
- The block sits between the core's I/O bus and the InpExtWorld*/OutExtWorld* pins.

Parameters:
DATA_WIDTH, 8, width of every data port and buffer.
WAIT_STATES, 0, extra cycles spent in ACCESS before acknowledge (0..15).

Ports:
clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
io_req  input  1  core request; held high until io_ack.
io_we  input  1  1 = write, 0 = read; sampled with io_req in IDLE.
io_addr  input  3  register address (map below).
io_wdata  input  DATA_WIDTH  write data; sampled in IDLE.
io_rdata  output  DATA_WIDTH  read data; valid only while io_ack = 1.
io_ack  output  1  one-cycle transaction acknowledge.
InpExtWorld1..InpExtWorld4  input  DATA_WIDTH each  external input bytes.
inp_strobe  input  4  bit i = input port i+1 data valid this cycle.
OutExtWorld1..OutExtWorld4  output  DATA_WIDTH each  registered output ports.
out_strobe  output  4  bit i pulses one cycle when OutExtWorld(i+1) is written.
rr_port  output  2  index of the port last served by a round-robin read.
rr_valid  output  1  1 = last round-robin read found a pending port.
io_irq  output  1  OR of all pending bits.

Behaviour:
Reset (when Reset = 1 at a rising edge, regardless of state):
- FSM goes to IDLE.
- These outputs and state are all 0: OutExtWorld1..4, out_strobe, io_ack, io_rdata, rr_port, rr_valid, io_irq, pending, overrun, input buffers, rr_ptr.
- A transaction in flight is dropped with no ack, and no write is committed.

Address map:
- 0..3: port data. A read returns input buffer i and clears pending[i]. A write loads OutExtWorld(i+1).
- 4: status. A read returns {overrun[3:0], pending[3:0]} and clears all overrun bits at ack.
- 5: round-robin data read.
- 6, 7: a read returns 0. Writes to 4..7 are ignored but still acknowledged.

FSM states: IDLE, ACCESS, ACK.
- IDLE -> ACCESS when io_req = 1. Latch io_we, io_addr and io_wdata.
- ACCESS holds for WAIT_STATES cycles, counted by a 4-bit down-counter, then goes to ACK.
- ACK: io_ack = 1 for exactly one cycle. io_rdata is driven and all side effects (pending clear, overrun clear, rr_ptr update, output write) take effect on entry to ACK. Then go to IDLE.
- Latency: io_req first seen at edge N -> io_ack high during cycle N+2+WAIT_STATES.
- If io_req is still high in IDLE after ACK, a new transaction starts. The core drops io_req in the ack cycle.

Output write:
- OutExtWorld(i+1) takes the latched wdata in the ACK cycle.
- out_strobe[i] is high in that same cycle only.
- Outputs hold their value otherwise.

Input capture, independent of the FSM:
- When inp_strobe[i] = 1: buffer[i] <= InpExtWorld(i+1) and pending[i] <= 1.
- If pending[i] was already 1, overrun[i] <= 1 (sticky).

Simultaneous events at the same edge:
- Strobe plus clearing read of the same port: the read returns the old buffer, the new data is captured, pending stays 1, and overrun is not set.
- Strobe plus status read: a strobe that sets overrun wins over the clear.

Round-robin read (addr 5):
- Search pending from rr_ptr upward, modulo 4, using the values at ACK entry.
- If the first pending port is k: io_rdata = buffer[k], pending[k] cleared, rr_ptr <= (k+1) mod 4, rr_port <= k, rr_valid <= 1.
- If none is pending: io_rdata = 0, rr_valid <= 0, and rr_ptr and rr_port are unchanged.

Registered outputs:
- io_rdata is 0 outside ACK.
- io_irq is registered from pending, i.e. one cycle after pending changes.

Test Plan:
1. Reset held 2 cycles mid-ACCESS (WAIT_STATES = 3) -> no io_ack; all outputs 0; the next read of addr 4 returns 0x00.
2. Write 0xA5 to addr 2 with WAIT_STATES = 0, req at edge N -> io_ack and out_strobe = 4'b0100 in cycle N+2; OutExtWorld3 = 0xA5 afterwards; other outputs stay 0.
3. Strobe port 1 with 0xAA, then port 1 again with 0xBB -> read addr 4 returns 0x11 and clears overrun; read addr 0 returns 0xBB; io_irq falls one cycle after ack.
4. Pending ports 2 and 4 (0xCC, 0x0F), rr_ptr = 0 -> first addr-5 read returns 0xCC with rr_port = 1; second returns 0x0F with rr_port = 3; third returns 0x00 with rr_valid = 0.
5. inp_strobe[2] with 0xF0 in the same cycle as the ACK of a read of addr 2 holding old data 0x11 -> io_rdata = 0x11; pending[2] remains 1; overrun[2] = 0; the next read returns 0xF0.
6. io_req held high across two reads of addr 6 -> two separate one-cycle acks with io_rdata = 0x00, separated by one IDLE cycle.

Source files
------------

// File: rtl/ext_world_io_ctrl.sv
// Request/acknowledge bus front-end that shares four external input byte ports
// (buffered, with pending/overrun flags) and four registered output ports with the core.
module ext_world_io_ctrl #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  Reset,
   input  logic                  io_req,
   input  logic                  io_we,
   input  logic [2:0]            io_addr,
   input  logic [DATA_WIDTH-1:0] io_wdata,
   output logic [DATA_WIDTH-1:0] io_rdata,
   output logic                  io_ack,
   input  logic [DATA_WIDTH-1:0] InpExtWorld1,
   input  logic [DATA_WIDTH-1:0] InpExtWorld2,
   input  logic [DATA_WIDTH-1:0] InpExtWorld3,
   input  logic [DATA_WIDTH-1:0] InpExtWorld4,
   input  logic [3:0]            inp_strobe,
   output logic [DATA_WIDTH-1:0] OutExtWorld1,
   output logic [DATA_WIDTH-1:0] OutExtWorld2,
   output logic [DATA_WIDTH-1:0] OutExtWorld3,
   output logic [DATA_WIDTH-1:0] OutExtWorld4,
   output logic [3:0]            out_strobe,
   output logic [1:0]            rr_port,
   output logic                  rr_valid,
   output logic                  io_irq
);

   localparam int unsigned NPORTS = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      wait_q, wait_d;
   logic                  we_q;
   logic [2:0]            addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [DATA_WIDTH-1:0] inp_w  [NPORTS];
   logic [DATA_WIDTH-1:0] buf_q  [NPORTS];
   logic [DATA_WIDTH-1:0] buf_d  [NPORTS];
   logic [DATA_WIDTH-1:0] out_q  [NPORTS];
   logic [DATA_WIDTH-1:0] out_d  [NPORTS];
   logic [3:0]            pend_q, pend_d;
   logic [3:0]            ovr_q, ovr_d;
   logic [3:0]            ostb_q, ostb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  ack_q, ack_d;
   logic [1:0]            rr_ptr_q, rr_ptr_d;
   logic [1:0]            rr_port_q, rr_port_d;
   logic                  rr_valid_q, rr_valid_d;
   logic                  irq_q;

   logic                  commit;
   logic [3:0]            rd_clr;
   logic                  ovr_clr;
   logic                  rr_hit;
   logic [1:0]            rr_sel;
   logic [1:0]            rr_idx;

   assign inp_w[0] = InpExtWorld1;
   assign inp_w[1] = InpExtWorld2;
   assign inp_w[2] = InpExtWorld3;
   assign inp_w[3] = InpExtWorld4;

   // Bus handshake sequencing; commit marks the edge that enters ACK
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      commit  = 1'b0;
      ack_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io_req) begin
               state_d = ST_ACCESS;
               wait_d  = CNT_W'(WAIT_STATES);
            end
         end
         ST_ACCESS: begin
            if (wait_q == '0) begin
               state_d = ST_ACK;
               commit  = 1'b1;
               ack_d   = 1'b1;
            end else begin
               wait_d = wait_q - CNT_W'(1);
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // First pending port at or after rr_ptr, wrapping modulo four
   always_comb begin
      rr_hit = 1'b0;
      rr_sel = rr_ptr_q;
      rr_idx = rr_ptr_q;
      for (int j = 0; j < int'(NPORTS); j++) begin
         rr_idx = rr_ptr_q + 2'(j);
         if (!rr_hit && pend_q[rr_idx]) begin
            rr_hit = 1'b1;
            rr_sel = rr_idx;
         end
      end
   end

   // Transaction side effects, all applied on the edge that enters ACK
   always_comb begin
      rd_clr     = '0;
      ovr_clr    = 1'b0;
      rdata_d    = '0;
      ostb_d     = '0;
      out_d      = out_q;
      rr_ptr_d   = rr_ptr_q;
      rr_port_d  = rr_port_q;
      rr_valid_d = rr_valid_q;
      if (commit) begin
         if (we_q) begin
            if (!addr_q[2]) begin
               out_d[addr_q[1:0]]  = wdata_q;
               ostb_d[addr_q[1:0]] = 1'b1;
            end
         end else begin
            case (addr_q)
               3'd0, 3'd1, 3'd2, 3'd3: begin
                  rdata_d             = buf_q[addr_q[1:0]];
                  rd_clr[addr_q[1:0]] = 1'b1;
               end
               3'd4: begin
                  rdata_d = DATA_WIDTH'({ovr_q, pend_q});
                  ovr_clr = 1'b1;
               end
               3'd5: begin
                  if (rr_hit) begin
                     rdata_d        = buf_q[rr_sel];
                     rd_clr[rr_sel] = 1'b1;
                     rr_ptr_d       = rr_sel + 2'd1;
                     rr_port_d      = rr_sel;
                     rr_valid_d     = 1'b1;
                  end else begin
                     rr_valid_d = 1'b0;
                  end
               end
               default: begin
                  rdata_d = '0;
               end
            endcase
         end
      end
   end

   // Input capture; a fresh strobe keeps pending set and outranks an overrun clear
   always_comb begin
      for (int i = 0; i < int'(NPORTS); i++) begin
         buf_d[i] = inp_strobe[i] ? inp_w[i] : buf_q[i];
      end
      pend_d = (pend_q & ~rd_clr) | inp_strobe;
      ovr_d  = (ovr_clr ? 4'b0000 : ovr_q) | (inp_strobe & pend_q & ~rd_clr);
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         pend_q     <= '0;
         ovr_q      <= '0;
         ostb_q     <= '0;
         rdata_q    <= '0;
         ack_q      <= 1'b0;
         rr_ptr_q   <= '0;
         rr_port_q  <= '0;
         rr_valid_q <= 1'b0;
         irq_q      <= 1'b0;
         for (int i = 0; i < int'(NPORTS); i++) begin
            buf_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         if (state_q == ST_IDLE && io_req) begin
            we_q    <= io_we;
            addr_q  <= io_addr;
            wdata_q <= io_wdata;
         end
         pend_q     <= pend_d;
         ovr_q      <= ovr_d;
         ostb_q     <= ostb_d;
         rdata_q    <= rdata_d;
         ack_q      <= ack_d;
         rr_ptr_q   <= rr_ptr_d;
         rr_port_q  <= rr_port_d;
         rr_valid_q <= rr_valid_d;
         irq_q      <= |pend_q;
         for (int i = 0; i < int'(NPORTS); i++) begin
            buf_q[i] <= buf_d[i];
            out_q[i] <= out_d[i];
         end
      end
   end

   assign io_rdata     = rdata_q;
   assign io_ack       = ack_q;
   assign OutExtWorld1 = out_q[0];
   assign OutExtWorld2 = out_q[1];
   assign OutExtWorld3 = out_q[2];
   assign OutExtWorld4 = out_q[3];
   assign out_strobe   = ostb_q;
   assign rr_port      = rr_port_q;
   assign rr_valid     = rr_valid_q;
   assign io_irq       = irq_q;

endmodule

// File: tb/tb_ext_world_io_ctrl.sv
// Bench for ext_world_io_ctrl: two instances (WAIT_STATES 0 and 3) driven by directed
// and random transactions, checked against a transaction-level model of the port registers.
module tb_ext_world_io_ctrl;

   localparam int unsigned DW   = 8;
   localparam int          NDUT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst   [NDUT];
   logic          req   [NDUT];
   logic          we    [NDUT];
   logic [2:0]    addr  [NDUT];
   logic [DW-1:0] wdata [NDUT];
   logic [DW-1:0] inp   [NDUT][4];
   logic [3:0]    stb   [NDUT];
   logic [DW-1:0] rdata [NDUT];
   logic          ack   [NDUT];
   logic [DW-1:0] outp  [NDUT][4];
   logic [3:0]    ostb  [NDUT];
   logic [1:0]    rrp   [NDUT];
   logic          rrv   [NDUT];
   logic          irq   [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      ext_world_io_ctrl #(
         .DATA_WIDTH (DW),
         .WAIT_STATES((g == 0) ? 0 : 3)
      ) u_dut (
         .clk         (clk),
         .Reset       (rst[g]),
         .io_req      (req[g]),
         .io_we       (we[g]),
         .io_addr     (addr[g]),
         .io_wdata    (wdata[g]),
         .io_rdata    (rdata[g]),
         .io_ack      (ack[g]),
         .InpExtWorld1(inp[g][0]),
         .InpExtWorld2(inp[g][1]),
         .InpExtWorld3(inp[g][2]),
         .InpExtWorld4(inp[g][3]),
         .inp_strobe  (stb[g]),
         .OutExtWorld1(outp[g][0]),
         .OutExtWorld2(outp[g][1]),
         .OutExtWorld3(outp[g][2]),
         .OutExtWorld4(outp[g][3]),
         .out_strobe  (ostb[g]),
         .rr_port     (rrp[g]),
         .rr_valid    (rrv[g]),
         .io_irq      (irq[g])
      );
   end

   // Reference model: register contents as seen by the core
   logic [DW-1:0] m_buf  [NDUT][4];
   logic [DW-1:0] m_out  [NDUT][4];
   logic [3:0]    m_pend [NDUT];
   logic [3:0]    m_ovr  [NDUT];
   int            m_rrptr  [NDUT];
   int            m_rrport [NDUT];
   logic          m_rrv    [NDUT];
   logic [DW-1:0] cdat [4];

   int errors = 0;
   int checks = 0;

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset(input int d);
      for (int i = 0; i < 4; i++) begin
         m_buf[d][i] = '0;
         m_out[d][i] = '0;
      end
      m_pend[d]   = '0;
      m_ovr[d]    = '0;
      m_rrptr[d]  = 0;
      m_rrport[d] = 0;
      m_rrv[d]    = 1'b0;
   endtask

   task automatic chk_outs(input int d, input string tag);
      for (int i = 0; i < 4; i++)
         chk($sformatf("d%0d %s out%0d", d, tag, i + 1), 32'(outp[d][i]), 32'(m_out[d][i]));
      chk($sformatf("d%0d %s rr_port", d, tag), 32'(rrp[d]), 32'(m_rrport[d]));
      chk($sformatf("d%0d %s rr_valid", d, tag), 32'(rrv[d]), 32'(m_rrv[d]));
   endtask

   // Apply strobes on the masked ports with data from cdat for one edge
   task automatic strobe(input int d, input logic [3:0] mask);
      @(negedge clk);
      stb[d] = mask;
      for (int i = 0; i < 4; i++) inp[d][i] = cdat[i];
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            if (m_pend[d][i]) m_ovr[d][i] = 1'b1;
            m_buf[d][i]  = cdat[i];
            m_pend[d][i] = 1'b1;
         end
      end
      @(negedge clk);
      stb[d] = '0;
   endtask

   // One bus transaction; cmask strobes (data cdat) land on the edge that starts the ack cycle
   task automatic xact(input int d, input logic we_v, input logic [2:0] a,
                       input logic [DW-1:0] wd, input logic [3:0] cmask);
      int            ws;
      int            ai;
      int            p;
      bit            found;
      bit            oclr;
      logic [DW-1:0] exp_rd;
      logic [3:0]    clr;
      logic [3:0]    exp_ostb;
      logic [3:0]    pend_before;
      ws = ws_of(d);
      ai = int'(a);
      @(negedge clk);
      req[d] = 1'b1; we[d] = we_v; addr[d] = a; wdata[d] = wd;
      @(posedge clk);
      for (int k = 0; k <= ws; k++) begin
         @(negedge clk);
         chk($sformatf("d%0d a%0d ack_early%0d", d, ai, k), 32'(ack[d]), 32'd0);
         if (k == ws) begin
            stb[d] = cmask;
            for (int i = 0; i < 4; i++) inp[d][i] = cdat[i];
         end
         @(posedge clk);
      end
      pend_before = m_pend[d];
      exp_rd = '0; clr = '0; exp_ostb = '0; oclr = 1'b0;
      if (we_v) begin
         if (ai < 4) begin
            m_out[d][ai] = wd;
            exp_ostb[ai] = 1'b1;
         end
      end else if (ai < 4) begin
         exp_rd  = m_buf[d][ai];
         clr[ai] = 1'b1;
      end else if (ai == 4) begin
         exp_rd = {m_ovr[d], m_pend[d]};
         oclr   = 1'b1;
      end else if (ai == 5) begin
         found = 1'b0;
         for (int j = 0; j < 4; j++) begin
            p = (m_rrptr[d] + j) % 4;
            if (!found && m_pend[d][p]) begin
               found       = 1'b1;
               exp_rd      = m_buf[d][p];
               clr[p]      = 1'b1;
               m_rrport[d] = p;
               m_rrptr[d]  = (p + 1) % 4;
            end
         end
         m_rrv[d] = found;
      end
      if (oclr) m_ovr[d] = '0;
      for (int i = 0; i < 4; i++) begin
         if (cmask[i]) begin
            if (m_pend[d][i] && !clr[i]) m_ovr[d][i] = 1'b1;
            m_buf[d][i]  = cdat[i];
            m_pend[d][i] = 1'b1;
         end else if (clr[i]) begin
            m_pend[d][i] = 1'b0;
         end
      end
      @(negedge clk);
      chk($sformatf("d%0d a%0d ack", d, ai), 32'(ack[d]), 32'd1);
      chk($sformatf("d%0d a%0d rdata", d, ai), 32'(rdata[d]), 32'(exp_rd));
      chk($sformatf("d%0d a%0d out_strobe", d, ai), 32'(ostb[d]), 32'(exp_ostb));
      chk($sformatf("d%0d a%0d irq_ack", d, ai), 32'(irq[d]), 32'(|pend_before));
      chk_outs(d, "ack");
      req[d] = 1'b0;
      stb[d] = '0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("d%0d a%0d ack_drop", d, ai), 32'(ack[d]), 32'd0);
      chk($sformatf("d%0d a%0d rdata_idle", d, ai), 32'(rdata[d]), 32'd0);
      chk($sformatf("d%0d a%0d ostb_idle", d, ai), 32'(ostb[d]), 32'd0);
      chk($sformatf("d%0d a%0d irq_after", d, ai), 32'(irq[d]), 32'(|m_pend[d]));
   endtask

   task automatic chk_reset_state(input int d);
      chk($sformatf("d%0d rst ack", d), 32'(ack[d]), 32'd0);
      chk($sformatf("d%0d rst rdata", d), 32'(rdata[d]), 32'd0);
      chk($sformatf("d%0d rst ostb", d), 32'(ostb[d]), 32'd0);
      chk($sformatf("d%0d rst irq", d), 32'(irq[d]), 32'd0);
      chk_outs(d, "rst");
   endtask

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0; stb[d] = '0;
         for (int i = 0; i < 4; i++) inp[d][i] = '0;
         m_reset(d);
      end
      for (int i = 0; i < 4; i++) cdat[i] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
      for (int d = 0; d < NDUT; d++) chk_reset_state(d);

      // Reset mid-ACCESS on the 3-wait-state instance drops the pending write
      cdat[0] = 8'h31; cdat[1] = 8'h32; cdat[2] = 8'h33; cdat[3] = 8'h34;
      strobe(1, 4'b1111);
      @(negedge clk);
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 3'd1; wdata[1] = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      rst[1] = 1'b1; req[1] = 1'b0;
      chk("d1 midrst ack0", 32'(ack[1]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("d1 midrst ack1", 32'(ack[1]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst[1] = 1'b0;
      m_reset(1);
      chk_reset_state(1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("d1 postrst ack%0d", k), 32'(ack[1]), 32'd0);
      end
      chk_outs(1, "postrst");
      xact(1, 1'b0, 3'd4, '0, 4'b0000);

      // Output write, zero wait states
      xact(0, 1'b1, 3'd2, 8'hA5, 4'b0000);
      chk("d0 out3 literal", 32'(outp[0][2]), 32'hA5);

      // Overrun on port 1, status read then data read
      cdat[0] = 8'hAA; strobe(0, 4'b0001);
      cdat[0] = 8'hBB; strobe(0, 4'b0001);
      xact(0, 1'b0, 3'd4, '0, 4'b0000);
      xact(0, 1'b0, 3'd0, '0, 4'b0000);
      xact(0, 1'b0, 3'd4, '0, 4'b0000);

      // Round-robin service of ports 2 and 4
      cdat[1] = 8'hCC; cdat[3] = 8'h0F;
      strobe(0, 4'b1010);
      xact(0, 1'b0, 3'd5, '0, 4'b0000);
      chk("d0 rr1 port literal", 32'(rrp[0]), 32'd1);
      xact(0, 1'b0, 3'd5, '0, 4'b0000);
      chk("d0 rr2 port literal", 32'(rrp[0]), 32'd3);
      xact(0, 1'b0, 3'd5, '0, 4'b0000);
      chk("d0 rr3 valid literal", 32'(rrv[0]), 32'd0);

      // Strobe coinciding with a clearing read of the same port
      cdat[2] = 8'h11; strobe(0, 4'b0100);
      cdat[2] = 8'hF0;
      xact(0, 1'b0, 3'd2, '0, 4'b0100);
      xact(0, 1'b0, 3'd4, '0, 4'b0000);
      xact(0, 1'b0, 3'd2, '0, 4'b0000);

      // io_req held across two back-to-back reads of address 6
      cdat[0] = 8'h77; strobe(0, 4'b0001);
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 3'd6;
      @(posedge clk);
      @(negedge clk); chk("d0 b2b access1", 32'(ack[0]), 32'd0);
      @(posedge clk);
      @(negedge clk); chk("d0 b2b ack1", 32'(ack[0]), 32'd1);
      chk("d0 b2b rdata1", 32'(rdata[0]), 32'd0);
      @(posedge clk);
      @(negedge clk); chk("d0 b2b idle", 32'(ack[0]), 32'd0);
      @(posedge clk);
      @(negedge clk); chk("d0 b2b access2", 32'(ack[0]), 32'd0);
      @(posedge clk);
      @(negedge clk); chk("d0 b2b ack2", 32'(ack[0]), 32'd1);
      chk("d0 b2b rdata2", 32'(rdata[0]), 32'd0);
      req[0] = 1'b0;
      @(posedge clk);
      @(negedge clk); chk("d0 b2b done", 32'(ack[0]), 32'd0);

      // Random mix of strobes and transactions on both instances
      for (int n = 0; n < 200; n++) begin
         int d;
         d = int'($urandom_range(0, 1));
         for (int i = 0; i < 4; i++) cdat[i] = DW'($urandom);
         if ($urandom_range(0, 2) == 0)
            strobe(d, 4'($urandom));
         else
            xact(d, 1'($urandom_range(0, 3) == 0), 3'($urandom), DW'($urandom),
                 ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom));
      end
      for (int d = 0; d < NDUT; d++) chk_outs(d, "final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
